// File: rtl/op_disp_pkg.sv
// Shared definitions for the operation-result display: FSM state encoding
// and active-low 7-segment patterns (SEG[6]=a .. SEG[0]=g).
package op_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Active-low segment patterns, bit order a,b,c,d,e,f,g from MSB to LSB
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h60;
  localparam logic [6:0] SEG_C     = 7'h31;
  localparam logic [6:0] SEG_D     = 7'h42;
  localparam logic [6:0] SEG_E     = 7'h30;
  localparam logic [6:0] SEG_F     = 7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble: 8 binary bits plus three BCD nibbles
  localparam int DD_W = 20;

endpackage

// File: rtl/seg7_enc.sv
// Combinational 4-bit digit to active-low 7-segment encoder with blanking.
module seg7_enc
  import op_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Look up the segment pattern; blank overrides the digit
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'h0: seg_o = SEG_0;
        4'h1: seg_o = SEG_1;
        4'h2: seg_o = SEG_2;
        4'h3: seg_o = SEG_3;
        4'h4: seg_o = SEG_4;
        4'h5: seg_o = SEG_5;
        4'h6: seg_o = SEG_6;
        4'h7: seg_o = SEG_7;
        4'h8: seg_o = SEG_8;
        4'h9: seg_o = SEG_9;
        4'hA: seg_o = SEG_A;
        4'hB: seg_o = SEG_B;
        4'hC: seg_o = SEG_C;
        4'hD: seg_o = SEG_D;
        4'hE: seg_o = SEG_E;
        4'hF: seg_o = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/op_result_disp.sv
// Captures one of four operation results on a rising ENABLE, converts it to
// decimal digits (double-dabble) and multiplexes them onto a 4-digit display.
// Define OP_RESULT_HEX_EN for hex display mode: no conversion, hundreds blank.
module op_result_disp
  import op_disp_pkg::*;
#(
  parameter int SCAN_W = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] op0,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  input  logic [7:0] op3,
  input  logic [1:0] DEC,
  input  logic       ENABLE,
  output logic [7:0] RESULT,
  output logic       VALID,
  output logic       BUSY,
  output logic [6:0] SEG,
  output logic [3:0] AN
);

  logic              sync1_q, sync2_q, prev_q;
  logic [1:0]        fill_q;
  logic              armed_q;
  logic              rise;
  logic              start;
  logic [7:0]        op_sel;

  state_e            state_q, state_d;
  logic [7:0]        result_q, result_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        hund_q, hund_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        units_q, units_d;

  logic [SCAN_W-1:0] scan_q;
  logic [1:0]        sel;
  logic [3:0]        digit;
  logic              blank;
  logic [3:0]        an_d;
  logic [6:0]        seg_enc;
  logic [6:0]        seg_q;
  logic [3:0]        an_q;

  // Synchronise ENABLE; fill_q marks when sync2 holds a real sample, so an
  // ENABLE already high at reset release never arms the edge detector
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= ENABLE;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && !sync2_q) armed_q <= 1'b1;
    end
  end

  assign rise = sync2_q & ~prev_q & armed_q;

`ifdef OP_RESULT_HEX_EN
  logic rise_q;

  // Hex mode starts one cycle after the rise so VALID lands one cycle after capture timing
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rise_q <= 1'b0;
    else        rise_q <= rise && (state_q == ST_IDLE);
  end

  assign start = rise_q;
`else
  logic [DD_W-1:0] shift_q, shift_d;
  logic [DD_W-1:0] dd_next;
  logic [2:0]      step_q, step_d;

  // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift left
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] s);
    logic [DD_W-1:0] t;
    t = s;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[DD_W-2:0], 1'b0};
  endfunction

  assign dd_next = dd_step(shift_q);
  assign start   = rise;
`endif

  // Select the operand addressed by DEC
  always_comb begin
    case (DEC)
      2'd0:    op_sel = op0;
      2'd1:    op_sel = op1;
      2'd2:    op_sel = op2;
      default: op_sel = op3;
    endcase
  end

  // FSM next state and capture/conversion datapath; digits commit on entry to DONE
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    idx_d    = idx_q;
    hund_d   = hund_q;
    tens_d   = tens_q;
    units_d  = units_q;
`ifndef OP_RESULT_HEX_EN
    shift_d  = shift_q;
    step_d   = step_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = op_sel;
          idx_d    = DEC;
`ifdef OP_RESULT_HEX_EN
          hund_d   = 4'd0;
          tens_d   = op_sel[7:4];
          units_d  = op_sel[3:0];
          state_d  = ST_DONE;
`else
          shift_d  = {12'd0, op_sel};
          step_d   = 3'd0;
          state_d  = ST_CONV;
`endif
        end
      end
      ST_CONV: begin
`ifdef OP_RESULT_HEX_EN
        state_d = ST_IDLE;
`else
        shift_d = dd_next;
        step_d  = step_q + 3'd1;
        if (step_q == 3'd7) begin
          hund_d  = dd_next[19:16];
          tens_d  = dd_next[15:12];
          units_d = dd_next[11:8];
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, captured result and digit registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      result_q <= 8'd0;
      idx_q    <= 2'd0;
      hund_q   <= 4'd0;
      tens_q   <= 4'd0;
      units_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      hund_q   <= hund_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
    end
  end

`ifndef OP_RESULT_HEX_EN
  // Conversion shift register and step counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_q <= '0;
      step_q  <= 3'd0;
    end else begin
      shift_q <= shift_d;
      step_q  <= step_d;
    end
  end
`endif

  // Free-running scan counter; wraps naturally
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) scan_q <= '0;
    else        scan_q <= scan_q + {{(SCAN_W-1){1'b0}}, 1'b1};
  end

  assign sel = scan_q[SCAN_W-1 -: 2];

  // Digit multiplexer: units, tens, hundreds, then the operation index
  always_comb begin
    digit = units_q;
    blank = 1'b0;
    an_d  = 4'b1110;
    case (sel)
      2'd0: begin
        digit = units_q;
        an_d  = 4'b1110;
      end
      2'd1: begin
        digit = tens_q;
        an_d  = 4'b1101;
      end
      2'd2: begin
        digit = hund_q;
        an_d  = 4'b1011;
`ifdef OP_RESULT_HEX_EN
        blank = 1'b1;
`endif
      end
      default: begin
        digit = {2'b00, idx_q};
        an_d  = 4'b0111;
      end
    endcase
  end

  seg7_enc u_seg7_enc (
    .digit_i (digit),
    .blank_i (blank),
    .seg_o   (seg_enc)
  );

  // Register SEG and AN together so the display never shows a mixed digit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_q <= SEG_0;
      an_q  <= 4'b1110;
    end else begin
      seg_q <= seg_enc;
      an_q  <= an_d;
    end
  end

  assign RESULT = result_q;
  assign VALID  = (state_q == ST_DONE);
  assign BUSY   = (state_q != ST_IDLE);
  assign SEG    = seg_q;
  assign AN     = an_q;

endmodule

// File: tb/tb_op_result_disp.sv
// Self-checking bench for op_result_disp with a result/display scoreboard.
`timescale 1ns/1ps
module tb_op_result_disp;

  localparam int SCAN_W = 4;
`ifdef OP_RESULT_HEX_EN
  localparam int EXP_EDGE = 4;
`else
  localparam int EXP_EDGE = 11;
`endif

  logic       CLK;
  logic       RST_N;
  logic [7:0] op0, op1, op2, op3;
  logic [1:0] DEC;
  logic       ENABLE;
  logic [7:0] RESULT;
  logic       VALID, BUSY;
  logic [6:0] SEG;
  logic [3:0] AN;

  typedef struct packed {
    logic [7:0] res;
    logic [6:0] s3;
    logic [6:0] s2;
    logic [6:0] s1;
    logic [6:0] s0;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  op_result_disp #(.SCAN_W(SCAN_W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .op0    (op0),
    .op1    (op1),
    .op2    (op2),
    .op3    (op3),
    .DEC    (DEC),
    .ENABLE (ENABLE),
    .RESULT (RESULT),
    .VALID  (VALID),
    .BUSY   (BUSY),
    .SEG    (SEG),
    .AN     (AN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'h01;  4'h1: p = 7'h4F;  4'h2: p = 7'h12;  4'h3: p = 7'h06;
      4'h4: p = 7'h4C;  4'h5: p = 7'h24;  4'h6: p = 7'h20;  4'h7: p = 7'h0F;
      4'h8: p = 7'h00;  4'h9: p = 7'h04;  4'hA: p = 7'h08;  4'hB: p = 7'h60;
      4'hC: p = 7'h31;  4'hD: p = 7'h42;  4'hE: p = 7'h30;  default: p = 7'h38;
    endcase
    return p;
  endfunction

  function automatic exp_t model(input logic [7:0] v, input logic [1:0] idx);
    exp_t e;
    e.res = v;
    e.s3  = pat({2'b00, idx});
`ifdef OP_RESULT_HEX_EN
    e.s2  = 7'h7F;
    e.s1  = pat(v[7:4]);
    e.s0  = pat(v[3:0]);
`else
    e.s2  = pat(4'(v / 100));
    e.s1  = pat(4'((v / 10) % 10));
    e.s0  = pat(4'(v % 10));
`endif
    return e;
  endfunction

  task automatic wait_valid(output int edge_n);
    edge_n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (VALID) begin
        edge_n = i;
        break;
      end
    end
  endtask

  task automatic check_display(input exp_t e);
    repeat (2) @(posedge CLK);
    for (int i = 0; i < (1 << SCAN_W); i++) begin
      @(negedge CLK);
      check("an_onehot", 32'($countones(~AN)), 32'd1);
      case (AN)
        4'b1110: check("seg_units", SEG, e.s0);
        4'b1101: check("seg_tens",  SEG, e.s1);
        4'b1011: check("seg_hund",  SEG, e.s2);
        4'b0111: check("seg_index", SEG, e.s3);
        default: ;
      endcase
    end
  endtask

  task automatic do_capture(input logic [1:0] idx, input logic [7:0] v);
    int   e;
    exp_t x;
    x = '0;
    case (idx)
      2'd0:    op0 = v;
      2'd1:    op1 = v;
      2'd2:    op2 = v;
      default: op3 = v;
    endcase
    DEC = idx;
    @(negedge CLK);
    ENABLE = 1'b1;
    sb_q.push_back(model(v, idx));
    wait_valid(e);
    check("valid_edge", 32'(e), 32'(EXP_EDGE));
    if (sb_q.size() == 0) check("sb_nonempty", 32'd0, 32'd1);
    else begin
      x = sb_q.pop_front();
      check("result", RESULT, x.res);
    end
    @(negedge CLK);
    check("valid_pulse", VALID, 1'b0);
    check("busy_after", BUSY, 1'b0);
    ENABLE = 1'b0;
    check_display(x);
  endtask

  initial begin
    int         nv, nb, ve;
    exp_t       x;
    logic [3:0] exp_an;

    RST_N  = 1'b1;
    ENABLE = 1'b0;
    DEC    = 2'd0;
    op0 = 8'd11; op1 = 8'd22; op2 = 8'd33; op3 = 8'd44;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_result", RESULT, 8'd0);
    check("rst_valid",  VALID,  1'b0);
    check("rst_busy",   BUSY,   1'b0);
    check("rst_an",     AN,     4'b1110);
    check("rst_seg",    SEG,    7'h01);
    RST_N = 1'b1;

    // Scan sequence: each anode holds for 4 cycles, then wraps
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
      check("scan_an", AN, exp_an);
      if (k % 4 == 2) check("scan_seg", SEG, 7'h01);
    end

    do_capture(2'd2, 8'd173);
    do_capture(2'd0, 8'd255);
    do_capture(2'd1, 8'hA7);

`ifndef OP_RESULT_HEX_EN
    // Busy retrigger: second rise with a different DEC while converting
    op1 = 8'd42; op3 = 8'd99; DEC = 2'd1;
    @(negedge CLK);
    ENABLE = 1'b1;
    sb_q.push_back(model(8'd42, 2'd1));
    nv = 0; ve = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (VALID) begin
        nv++;
        if (ve < 0) ve = e;
      end
      if (e == 3) begin
        ENABLE = 1'b0;
        DEC    = 2'd3;
      end
      if (e == 5) begin
        check("busy_conv", BUSY, 1'b1);
        ENABLE = 1'b1;
      end
    end
    check("retrig_valid_count", 32'(nv), 32'd1);
    check("retrig_valid_edge", 32'(ve), 32'd11);
    x = sb_q.pop_front();
    check("retrig_result", RESULT, x.res);
    ENABLE = 1'b0;
    check_display(x);

    // Reset during conversion
    op0 = 8'd77; DEC = 2'd0;
    @(negedge CLK);
    ENABLE = 1'b1;
    repeat (7) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("midrst_valid",  VALID,  1'b0);
    check("midrst_busy",   BUSY,   1'b0);
    check("midrst_result", RESULT, 8'd0);
    check("midrst_an",     AN,     4'b1110);
    check("midrst_seg",    SEG,    7'h01);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    nv = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (VALID) nv++;
      if (BUSY)  nb++;
    end
    check("held_enable_valid", 32'(nv), 32'd0);
    check("held_enable_busy",  32'(nb), 32'd0);
    check("held_enable_result", RESULT, 8'd0);
    ENABLE = 1'b0;
    repeat (5) @(negedge CLK);
`endif

    do_capture(2'd3, 8'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/op_result_disp.md
OP_RESULT_DISP -- requirements
Module: op_result_disp

Interface
REQ-001 SHALL have parameter SCAN_W, default 16, meaning the width of the display scan counter; its top 2 bits select the active digit.
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: the reset; it is asynchronous and active-low.
REQ-004 SHALL have ports op0, op1, op2, op3, input, 8 bits each: the four operation results from the operation/decoder stage.
REQ-005 SHALL have port DEC, input, 2 bits: the index of the operation to capture.
REQ-006 SHALL have port ENABLE, input, 1 bit: the capture request; it is asynchronous to CLK, and only a rising level counts.
REQ-007 SHALL have port RESULT, output, 8 bits: the captured operation result.
REQ-008 SHALL have port VALID, output, 1 bit: a one-cycle pulse marking that RESULT and the display digits have been updated.
REQ-009 SHALL have port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port SEG, output, 7 bits: segments a..g (SEG[6]=a), active-low.
REQ-011 SHALL have port AN, output, 4 bits: digit anodes, active-low, exactly one low at any time.

Function
REQ-012 SHALL pass ENABLE through a two-flop synchronizer and a third "previous" flop; the rise condition is sync2 high while prev is low.
REQ-013 SHALL run an FSM with three states: IDLE, CONV and DONE.
REQ-014 SHALL, on a rise condition in IDLE, latch op[DEC] into RESULT, latch DEC into the index register, load the shift register, clear the step counter, and go to CONV.
REQ-015 SHALL, in CONV, perform one double-dabble step per cycle over 8 cycles (step counter 0..7), going to DONE at step 7.
REQ-016 SHALL, in DONE, load the hundreds, tens and units digit registers, assert VALID for exactly that cycle, and return to IDLE.
REQ-017 SHALL, counting the edge that first samples ENABLE high as edge 1, capture at edge 3 and enter DONE at edge 11, so VALID is high between edges 11 and 12.
REQ-018 SHALL ignore rise conditions while BUSY, with no queuing; a level held high SHALL produce only one capture.
REQ-019 SHALL leave RESULT and the displayed digits unchanged between VALID pulses.
REQ-020 SHALL run the scan counter freely and wrap at 2^SCAN_W−1 with no gap.
REQ-021 SHALL map the top 2 bits of the scan counter to digits as follows: 0 drives AN[0] with units; 1 drives AN[1] with tens; 2 drives AN[2] with hundreds; 3 drives AN[3] with the op index (0..3).
REQ-022 SHALL register SEG and AN so that they change together.
REQ-023 SHALL keep the maximum value 255 fully representable: hundreds digit 2, tens 5, units 5.

Reset
REQ-024 SHALL, on RST_N low, immediately clear to 0: RESULT, the index, the digits, the synchronizer and previous flops, the step counter and the scan counter.
REQ-025 SHALL, on RST_N low, force VALID=0, BUSY=0, FSM=IDLE, AN=4'b1110 and SEG equal to the pattern for "0".
REQ-026 SHALL, if reset is asserted mid-conversion, abort the conversion without producing a VALID pulse.
REQ-027 SHALL, after release, not capture an ENABLE that was already high; a fresh low-to-high transition is required.

Configuration
REQ-028 SHALL use the macro OP_RESULT_HEX_EN to select hex display mode.
REQ-029 SHALL, when OP_RESULT_HEX_EN is defined, skip CONV (IDLE→DONE directly, VALID between edges 4 and 5).
REQ-030 SHALL, when OP_RESULT_HEX_EN is defined, set units=RESULT[3:0] and tens=RESULT[7:4], and blank the hundreds digit (all segments off).
REQ-031 SHALL, when OP_RESULT_HEX_EN is undefined, provide the decimal behaviour of REQ-015 to REQ-017.

Structure
REQ-032 SHALL place the FSM state encoding, the 7-segment pattern constants for 0–F and the BLANK pattern constant in the shared package op_disp_pkg.
REQ-033 SHALL implement the combinational 4-bit to 7-segment mapping in the sub-module seg7_enc, with a single instance after the digit mux.

Verification
REQ-034 SHALL test decimal capture: op2=8'd173, DEC=2, ENABLE rises → VALID between edges 11 and 12, RESULT=173, digits 2/1/7/3 on AN[3..0].
REQ-035 SHALL test the boundary values: op0=8'd255 → digits 0/2/5/5; op3=8'd0 → digits 3/0/0/0.
REQ-036 SHALL test a busy retrigger: a second ENABLE rise at edge 6 with a different DEC → ignored, one VALID pulse, first result kept.
REQ-037 SHALL test reset mid-conversion: RST_N low at edge 7 → no VALID, RESULT=0, AN=1110, SEG shows "0".
REQ-038 SHALL test OP_RESULT_HEX_EN: op1=8'hA7, DEC=1 → VALID between edges 4 and 5, digits 1/blank/A/7.
REQ-039 SHALL test the scan sequence: SCAN_W=4 → AN steps 1110, 1101, 1011, 0111 every 4 cycles, then wraps.
